// File: rtl/booth_mult_unit_if.sv
// Handshake and operand/result bundle between the ALU control and the Booth multiplier.
interface booth_mult_unit_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock, WIDTH steps per multiply.
module booth_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  booth_mult_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     acc_sh_s;
  logic [WIDTH-1:0]   q_sh_s;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Booth recode of {Q[0], q_-1}, followed by the arithmetic shift of {acc, Q}
  always_comb begin
    sum_s = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum_s = acc_q + m_q;
      2'b10:   sum_s = acc_q - m_q;
      default: sum_s = acc_q;
    endcase
    acc_sh_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_sh_s   = {sum_s[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          q_d     = bus.multiplier;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_sh_s;
        q_d   = q_sh_s;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        // Last step: the low 2*WIDTH bits of the shifted {acc, Q} are the exact product
        if (cnt_q == CW'(1)) begin
          prod_d  = {acc_sh_s[WIDTH-1:0], q_sh_s};
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.product = prod_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult_unit.sv
// Randomized and directed bench for booth_mult_unit against a cycle-count/arithmetic reference model.
module tb_booth_mult_unit;

  localparam int W = 32;

  logic Clk;
  logic reset;
  int   passed;
  int   total;
  int   cyc;
  logic check_en;

  booth_mult_unit_if #(.WIDTH(W)) bus ();

  booth_mult_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: remaining cycles until IDLE, result committed one cycle before return to IDLE
  int          m_rem;
  logic [63:0] m_prod;
  logic [63:0] m_pend;

  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_prod <= 64'd0;
      m_pend <= 64'd0;
    end else if (m_rem == 0) begin
      if (bus.start) begin
        m_rem  <= W + 1;
        m_pend <= ref_mul(bus.multiplicand, bus.multiplier);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) m_prod <= m_pend;
    end
  end

  always @(negedge Clk) begin
    if (check_en && !reset) begin
      chk("model_busy", 64'(bus.busy), 64'(m_rem > 0));
      chk("model_done", 64'(bus.done), 64'(m_rem == 1));
      chk("model_product", bus.product, m_prod);
    end
  end

  // One multiply; pulse_at>0 injects an ignored start (2x2) at that cycle offset
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input string nm, input int pulse_at);
    int n;
    @(negedge Clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(negedge Clk);
    n = 1;
    bus.start = 1'b0;
    chk({nm, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    while (!bus.done && n < 60) begin
      if (n == pulse_at) begin
        bus.start        = 1'b1;
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd2;
      end else begin
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end
      @(negedge Clk);
      n = n + 1;
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'd33);
    chk({nm, "_product"}, bus.product, lit);
    @(negedge Clk);
    chk({nm, "_done_width"}, 64'(bus.done), 64'd0);
    chk({nm, "_busy_clear"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] corner [5];
    passed   = 0;
    total    = 0;
    cyc      = 0;
    check_en = 1'b0;
    reset    = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    corner[0] = 32'h8000_0000;
    corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h0000_0000;
    corner[4] = 32'h0000_0001;

    repeat (2) @(negedge Clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_product", bus.product, 64'd0);
    reset = 1'b0;
    check_en = 1'b1;

    run_op(32'd3, 32'd4, 64'h0000_0000_0000_000C, "t1_3x4", 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "t2_m1xm1", 0);
    run_op(32'hFFFF_FFF9, 32'd5, 64'hFFFF_FFFF_FFFF_FFDD, "t2_m7x5", 0);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "t3_minxmin", 0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "t3_maxxmin", 0);
    run_op(32'd0, 32'h8000_0000, 64'h0, "t3_zeroxmin", 0);
    run_op(32'd6, 32'd7, 64'd42, "t4_ignored_start", 10);

    // Asynchronous reset in the middle of a 9x9 operation
    @(negedge Clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (14) @(negedge Clk);
    @(posedge Clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_async_busy", 64'(bus.busy), 64'd0);
    chk("t5_async_done", 64'(bus.done), 64'd0);
    chk("t5_async_product", bus.product, 64'd0);
    @(negedge Clk);
    reset = 1'b0;
    run_op(32'd2, 32'd3, 64'd6, "t5_after_reset", 0);

    // start held high across two back-to-back operations
    @(negedge Clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd5;
    n = 0;
    @(negedge Clk);
    while (!bus.done && n < 60) begin
      @(negedge Clk);
      n = n + 1;
    end
    t1 = cyc;
    chk("t6_first_product", bus.product, 64'd25);
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd3;
    n = 0;
    @(negedge Clk);
    while (!bus.done && n < 60) begin
      chk("t6_product_hold", bus.product, 64'd25);
      @(negedge Clk);
      n = n + 1;
    end
    t2 = cyc;
    bus.start = 1'b0;
    chk("t6_done_spacing", 64'(t2 - t1), 64'd34);
    chk("t6_second_product", bus.product, 64'd9);

    // Randomized operands, with corner values mixed in
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 4)];
      run_op(a, b, ref_mul(a, b), "rand", (i % 3 == 0) ? 17 : 0);
    end

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
